gpr_wb_sched: RTL

//  Schedules NREQ write-back producers (ALU, MUL/DIV, LSU, SPR-move) onto the two GPR write ports (wr0/wr1).

---
 rtl/gpr_wb_sched_pkg.sv | 28 ++
 rtl/gpr_wb_sched_if.sv | 40 ++++
 rtl/gpr_wb_pick.sv | 51 +++++
 rtl/gpr_wb_sched.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/gpr_wb_sched_pkg.sv
// Shared types and constants for the GPR write-back scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpr_wb_sched_pkg;

  localparam int GPR_DEPTH = 5;   // GPR address width
  localparam int GPR_WIDTH = 32;  // GPR data width
  localparam int GPR_SIZE  = 32;  // number of GPRs
  localparam int WB_NREQ   = 4;   // default number of write-back requesters
  localparam int WB_CNT_W  = 2;   // in-flight counter width per GPR

  typedef logic [WB_CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

  // One registered GPR write port.
  typedef struct packed {
    logic                 wr;
    logic [GPR_DEPTH-1:0] addr;
    logic [GPR_WIDTH-1:0] data;
  } wr_port_t;

  // Index increment with wrap at n (n need not be a power of two).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/gpr_wb_sched_if.sv
// Bundle between execute-stage producers/decode and the write-back scheduler.
// Latency: n/a (wires only).
// Backpressure: req_ready is the per-requester grant; iss_stall holds decode.
interface gpr_wb_sched_if
  import gpr_wb_sched_pkg::*;
#(
  parameter int NREQ = WB_NREQ
) ();

  logic                      flush;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ*GPR_DEPTH-1:0] req_addr;
  logic [NREQ*GPR_WIDTH-1:0] req_data;
  logic [NREQ-1:0]           req_ready;
  logic                      iss_valid;
  logic [GPR_DEPTH-1:0]      iss_addr;
  logic                      iss_stall;
  logic [GPR_SIZE-1:0]       pending;
  logic                      wr0;
  logic [GPR_DEPTH-1:0]      waddr0;
  logic [GPR_WIDTH-1:0]      wd0;
  logic                      wr1;
  logic [GPR_DEPTH-1:0]      waddr1;
  logic [GPR_WIDTH-1:0]      wd1;

  // Producer/decode side.
  modport master (
    output flush, req_valid, req_addr, req_data, iss_valid, iss_addr,
    input  req_ready, iss_stall, pending,
    input  wr0, waddr0, wd0, wr1, waddr1, wd1
  );

  // Scheduler side.
  modport slave (
    input  flush, req_valid, req_addr, req_data, iss_valid, iss_addr,
    output req_ready, iss_stall, pending,
    output wr0, waddr0, wd0, wr1, waddr1, wd1
  );

endinterface

// File: rtl/gpr_wb_pick.sv
// Rotating two-grant picker: first valid from rr_ptr wins port 0, next valid with a different address wins port 1.
// Latency: purely combinational.
// Backpressure: requesters not granted (incl. same-address losers) simply see no grant and retry.
module gpr_wb_pick
  import gpr_wb_sched_pkg::*;
#(
  parameter int NREQ  = WB_NREQ,
  parameter int AW    = GPR_DEPTH,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]    valid,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NREQ-1:0]    grant,
  output logic [PTR_W-1:0]   idx_a,
  output logic [PTR_W-1:0]   idx_b,
  output logic               v_a,
  output logic               v_b
);

  logic [AW-1:0] a_addr;
  int            j;

  // Scan requesters in rotated order, taking at most two with distinct addresses.
  always_comb begin
    grant  = '0;
    idx_a  = '0;
    idx_b  = '0;
    v_a    = 1'b0;
    v_b    = 1'b0;
    a_addr = '0;
    j      = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (valid[j]) begin
        if (!v_a) begin
          v_a      = 1'b1;
          idx_a    = PTR_W'(j);
          a_addr   = addr[j*AW +: AW];
          grant[j] = 1'b1;
        end else if (!v_b && (addr[j*AW +: AW] != a_addr)) begin
          v_b      = 1'b1;
          idx_b    = PTR_W'(j);
          grant[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gpr_wb_sched.sv
// Schedules NREQ write-back producers onto two GPR write ports and tracks in-flight writes per GPR.
// Latency: 1 clk from grant (req_ready) to wr0/wr1; req_ready and iss_stall are combinational.
// Backpressure: ungranted requesters hold until ready; decode stalls when its target counter is saturated.
module gpr_wb_sched
  import gpr_wb_sched_pkg::*;
#(
  parameter int NREQ = WB_NREQ
) (
  input  logic          clk,
  input  logic          rst,
  gpr_wb_sched_if.slave bus
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      valid_g;
  logic [NREQ-1:0]      grant;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     idx_a;
  logic [PTR_W-1:0]     idx_b;
  logic [PTR_W-1:0]     idx_last;
  logic                 v_a;
  logic                 v_b;
  logic [GPR_DEPTH-1:0] addr_a;
  logic [GPR_DEPTH-1:0] addr_b;
  logic [GPR_WIDTH-1:0] data_a;
  logic [GPR_WIDTH-1:0] data_b;
  wr_port_t             port0;
  wr_port_t             port1;
  cnt_t                 cnt     [GPR_SIZE];
  cnt_t                 cnt_nxt [GPR_SIZE];
  logic [GPR_SIZE-1:0]  inc_vec;
  logic [GPR_SIZE-1:0]  dec_vec;
  logic [GPR_SIZE-1:0]  busy_vec;
  logic                 iss_hit;
  logic                 iss_stall;
  logic                 iss_take;

  // Flush hides every requester from the picker, so no grant and no decrement happen.
  assign valid_g = bus.flush ? '0 : bus.req_valid;

  gpr_wb_pick #(
    .NREQ  (NREQ),
    .AW    (GPR_DEPTH),
    .PTR_W (PTR_W)
  ) u_pick (
    .valid  (valid_g),
    .addr   (bus.req_addr),
    .rr_ptr (rr_ptr),
    .grant  (grant),
    .idx_a  (idx_a),
    .idx_b  (idx_b),
    .v_a    (v_a),
    .v_b    (v_b)
  );

  assign bus.req_ready = grant;
  assign addr_a   = bus.req_addr[int'(idx_a)*GPR_DEPTH +: GPR_DEPTH];
  assign addr_b   = bus.req_addr[int'(idx_b)*GPR_DEPTH +: GPR_DEPTH];
  assign data_a   = bus.req_data[int'(idx_a)*GPR_WIDTH +: GPR_WIDTH];
  assign data_b   = bus.req_data[int'(idx_b)*GPR_WIDTH +: GPR_WIDTH];
  assign idx_last = v_b ? idx_b : idx_a;

  // Round-robin pointer moves just past the last requester granted this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (v_a) begin
      rr_ptr <= PTR_W'(wrap_inc(int'(idx_last), NREQ));
    end
  end

  // Register the granted pair onto the GPR write ports; address/data only load on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port0 <= '0;
      port1 <= '0;
    end else begin
      port0.wr <= v_a;
      port1.wr <= v_b;
      if (v_a) begin
        port0.addr <= addr_a;
        port0.data <= data_a;
      end
      if (v_b) begin
        port1.addr <= addr_b;
        port1.data <= data_b;
      end
    end
  end

  assign bus.wr0    = port0.wr;
  assign bus.waddr0 = port0.addr;
  assign bus.wd0    = port0.data;
  assign bus.wr1    = port1.wr;
  assign bus.waddr1 = port1.addr;
  assign bus.wd1    = port1.data;

  // A saturated target is fine to issue if one of its writes retires in the same cycle.
  assign iss_hit   = (v_a && (addr_a == bus.iss_addr)) || (v_b && (addr_b == bus.iss_addr));
  assign iss_stall = bus.iss_valid && (cnt[bus.iss_addr] == CNT_MAX) && !iss_hit;
  assign iss_take  = bus.iss_valid && !iss_stall && !bus.flush;
  assign bus.iss_stall = iss_stall;

  // Per-register counter update: issue +1, grant -1, both cancel; flush clears all.
  always_comb begin
    inc_vec  = '0;
    dec_vec  = '0;
    busy_vec = '0;
    for (int r = 0; r < GPR_SIZE; r++) begin
      cnt_nxt[r]  = cnt[r];
      inc_vec[r]  = iss_take && (bus.iss_addr == GPR_DEPTH'(r));
      dec_vec[r]  = (v_a && (addr_a == GPR_DEPTH'(r))) || (v_b && (addr_b == GPR_DEPTH'(r)));
      busy_vec[r] = (cnt[r] != '0);
      if (bus.flush) begin
        cnt_nxt[r] = '0;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        if (cnt[r] != CNT_MAX) cnt_nxt[r] = cnt[r] + cnt_t'(1);
      end else if (dec_vec[r] && !inc_vec[r] && busy_vec[r]) begin
        cnt_nxt[r] = cnt[r] - cnt_t'(1);
      end
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < GPR_SIZE; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < GPR_SIZE; r++) cnt[r] <= cnt_nxt[r];
    end
  end

  assign bus.pending = busy_vec;

`ifndef SYNTHESIS
  // A write-back to a register with nothing in flight means decode and the producers disagree.
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    ((dec_vec & ~inc_vec & ~busy_vec) == '0))
    else $error("gpr_wb_sched: write-back to register with no in-flight issue");
`endif

endmodule
